// File: rtl/gemm_drain_counter.sv
// gemm_drain_counter: receive-side drain controller for the GEMM array edge.
// Optional sticky protocol error flag built when GEMM_DRAIN_ERR_EN is defined.
module gemm_drain_counter #(
  parameter int CNT       = 14,
  parameter int CNT_WIDTH = 4,
  parameter int LAT       = 3,
  parameter int LAT_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] len_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 last_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN,
    DONE
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LIM  = CNT_WIDTH'(CNT);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = CNT_WIDTH'(CNT - 1);
  localparam logic [LAT_WIDTH-1:0] LAT_INIT =
    (LAT > 0) ? LAT_WIDTH'(LAT - 1) : '0;
  localparam bit SKIP_FILL = (LAT == 0);

  state_t state;
  state_t state_nx;

  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_nx;
  logic [CNT_WIDTH-1:0] cnt_load;
  logic [LAT_WIDTH-1:0] lat;
  logic [LAT_WIDTH-1:0] lat_nx;

  logic len_ok;
  logic accept;
  logic cnt_zero;

  // Zero or oversize lengths fall back to a full tile.
  assign len_ok   = (len_i != '0) && (len_i <= CNT_LIM);
  assign cnt_load = len_ok ? (len_i - 1'b1) : CNT_MAX;

  assign accept   = (state == DRAIN) && valid_i;
  assign cnt_zero = (cnt == '0);

  assign ready_o  = (state == DRAIN);
  assign busy_o   = (state != IDLE);
  assign done_o   = (state == DONE);
  assign cnt_o    = cnt;
  assign last_o   = accept && cnt_zero;

  // State, beat counter and latency counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      lat   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      lat   <= lat_nx;
    end
  end

  // Next-state and counter update; counters only move in their own state.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    lat_nx   = lat;
    unique case (state)
      IDLE: begin
        if (start_i) begin
          cnt_nx   = cnt_load;
          lat_nx   = LAT_INIT;
          state_nx = SKIP_FILL ? DRAIN : FILL;
        end
      end
      FILL: begin
        if (lat == '0) begin
          state_nx = DRAIN;
        end else begin
          lat_nx = lat - 1'b1;
        end
      end
      DRAIN: begin
        if (accept) begin
          if (cnt_zero) begin
            state_nx = DONE;
          end else begin
            cnt_nx = cnt - 1'b1;
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

`ifdef GEMM_DRAIN_ERR_EN
  logic err;
  logic err_set;
  logic err_clr;

  assign err_set = (valid_i && ((state == FILL) || (state == DONE)))
                 || (start_i && (state != IDLE));
  assign err_clr = start_i && (state == IDLE);

  // Sticky protocol error, cleared by the next accepted start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (err_clr) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end
  end

  assign err_o = err;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_gemm_drain_counter.sv
// tb_gemm_drain_counter: directed checks of the drain controller.
// Covers clamping, gaps, ignored restarts, mid-drain reset and LAT=0.
module tb_gemm_drain_counter;

  localparam int LAT = 3;

`ifdef GEMM_DRAIN_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic [3:0] len_i = '0;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic [3:0] cnt_o;
  logic       last_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;

  logic       start0 = 1'b0;
  logic [3:0] len0 = '0;
  logic       valid0 = 1'b0;
  logic       ready0;
  logic [3:0] cnt0;
  logic       last0;
  logic       busy0;
  logic       done0;
  logic       err0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  gemm_drain_counter #(
    .CNT(14), .CNT_WIDTH(4), .LAT(3), .LAT_WIDTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .len_i(len_i),
    .valid_i(valid_i), .ready_o(ready_o), .cnt_o(cnt_o),
    .last_o(last_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  gemm_drain_counter #(
    .CNT(14), .CNT_WIDTH(4), .LAT(0), .LAT_WIDTH(1)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .start_i(start0), .len_i(len0),
    .valid_i(valid0), .ready_o(ready0), .cnt_o(cnt0),
    .last_o(last0), .busy_o(busy0), .done_o(done0), .err_o(err0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start a drain with valid_i held high and check every cycle.
  task automatic drain(input int len, input int n, input string tag);
    start_i = 1'b1;
    len_i   = 4'(len);
    valid_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk({tag, "_busy"}, 32'(busy_o), 32'd1);
    chk({tag, "_err_clr"}, 32'(err_o), 32'd0);
    for (int i = 0; i < LAT; i++) begin
      chk({tag, "_fill_rdy"}, 32'(ready_o), 32'd0);
      tick();
    end
    for (int b = 0; b < n; b++) begin
      chk({tag, "_rdy"}, 32'(ready_o), 32'd1);
      chk({tag, "_cnt"}, 32'(cnt_o), 32'(n - 1 - b));
      chk({tag, "_last"}, 32'(last_o), 32'(b == n - 1));
      tick();
    end
    chk({tag, "_done"}, 32'(done_o), 32'd1);
    chk({tag, "_done_rdy"}, 32'(ready_o), 32'd0);
    chk({tag, "_done_busy"}, 32'(busy_o), 32'd1);
    tick();
    valid_i = 1'b0;
    chk({tag, "_done_end"}, 32'(done_o), 32'd0);
    chk({tag, "_idle"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    logic [4:0] tv;
    logic [3:0] tcnt [5];
    logic [4:0] tlast;

    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_cnt", 32'(cnt_o), 32'd0);
    chk("rst_last", 32'(last_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst0_cnt", 32'(cnt0), 32'd0);

    drain(4, 4, "len4");
    drain(0, 14, "len0");
    drain(15, 14, "len15");
    drain(14, 14, "len14");

    // valid gaps: 1,0,1,0,1
    tv = 5'b10101;
    tcnt[0] = 4'd2; tcnt[1] = 4'd1; tcnt[2] = 4'd1;
    tcnt[3] = 4'd0; tcnt[4] = 4'd0;
    tlast = 5'b10000;
    start_i = 1'b1;
    len_i   = 4'd3;
    valid_i = 1'b0;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      valid_i = tv[i];
      #1;
      chk("gap_rdy", 32'(ready_o), 32'd1);
      chk("gap_cnt", 32'(cnt_o), 32'(tcnt[i]));
      chk("gap_last", 32'(last_o), 32'(tlast[i]));
      tick();
    end
    valid_i = 1'b0;
    chk("gap_done", 32'(done_o), 32'd1);
    tick();
    chk("gap_idle", 32'(busy_o), 32'd0);

    // start re-pulsed during FILL and DRAIN
    start_i = 1'b1;
    len_i   = 4'd2;
    tick();
    len_i   = 4'd5;
    tick();
    start_i = 1'b0;
    chk("rp_fill2", 32'(ready_o), 32'd0);
    tick();
    chk("rp_fill3", 32'(ready_o), 32'd0);
    tick();
    chk("rp_drain_rdy", 32'(ready_o), 32'd1);
    chk("rp_drain_cnt", 32'(cnt_o), 32'd1);
    valid_i = 1'b1;
    #1;
    chk("rp_last0", 32'(last_o), 32'd0);
    tick();
    start_i = 1'b1;
    #1;
    chk("rp_cnt_hold", 32'(cnt_o), 32'd0);
    chk("rp_last1", 32'(last_o), 32'd1);
    tick();
    start_i = 1'b0;
    valid_i = 1'b0;
    chk("rp_done", 32'(done_o), 32'd1);
    tick();
    chk("rp_idle", 32'(busy_o), 32'd0);
    chk("rp_err", 32'(err_o), 32'(ERR_EXP));
    drain(3, 3, "rp_next");

    // reset after 2 of 6 beats
    start_i = 1'b1;
    len_i   = 4'd6;
    valid_i = 1'b1;
    tick();
    start_i = 1'b0;
    tick();
    tick();
    tick();
    tick();
    tick();
    chk("mr_cnt", 32'(cnt_o), 32'd3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mr_ready", 32'(ready_o), 32'd0);
    chk("mr_busy", 32'(busy_o), 32'd0);
    chk("mr_done", 32'(done_o), 32'd0);
    chk("mr_cnt0", 32'(cnt_o), 32'd0);
    chk("mr_last", 32'(last_o), 32'd0);
    chk("mr_err", 32'(err_o), 32'd0);
    valid_i = 1'b0;
    tick();
    chk("mr_ready2", 32'(ready_o), 32'd0);
    drain(2, 2, "mr_len2");

    // LAT=0 instance
    start0 = 1'b1;
    len0   = 4'd1;
    valid0 = 1'b1;
    tick();
    start0 = 1'b0;
    chk("l0_ready", 32'(ready0), 32'd1);
    chk("l0_last", 32'(last0), 32'd1);
    chk("l0_cnt", 32'(cnt0), 32'd0);
    tick();
    valid0 = 1'b0;
    chk("l0_done", 32'(done0), 32'd1);
    chk("l0_last_off", 32'(last0), 32'd0);
    tick();
    chk("l0_idle", 32'(busy0), 32'd0);
    chk("l0_done_off", 32'(done0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gemm_drain_counter.md
# gemm_drain_counter

Down-counting drain controller that sits at the output edge of the GEMM systolic array and consumes result rows. It is the receive-side counterpart of the input-side up-counting row issuer. After a start, it waits a fixed pipeline-fill latency, then accepts exactly N result beats over a valid/ready handshake. It flags the final beat and pulses done when the tile is fully drained.

## Interface
Parameters:
- CNT, 14: maximum beats per tile. Also the clamp value for out-of-range lengths.
- CNT_WIDTH, 4: width of the beat counter and of len_i. Must satisfy 2^CNT_WIDTH > CNT.
- LAT, 3: array fill latency in cycles between start and the first ready. 0 is legal.
- LAT_WIDTH, 2: width of the latency counter. Must hold LAT.

Ports:
- clk: input, 1, clock.
- rst_n: input, 1, reset; synchronous, active-low.
- start_i: input, 1, begin a drain. Honoured only in IDLE.
- len_i: input, CNT_WIDTH, beats to accept. Sampled with start_i.
- valid_i: input, 1, array output row valid.
- ready_o: output, 1, controller accepts a beat this cycle.
- cnt_o: output, CNT_WIDTH, remaining beats minus one (the counter register).
- last_o: output, 1, current accepted beat is the final one.
- busy_o: output, 1, state is not IDLE.
- done_o: output, 1, one-cycle pulse after the final beat.
- err_o: output, 1, sticky protocol error. Only meaningful with the macro enabled.

## Operation
- FSM states: IDLE, FILL, DRAIN, DONE.
- IDLE:
  - ready_o=0.
  - start_i loads cnt = N-1, where N = len_i. len_i==0 or len_i>CNT uses N=CNT.
  - Loads lat = LAT-1, then goes to FILL. If LAT==0, goes directly to DRAIN.
- FILL:
  - ready_o=0.
  - lat decrements each cycle. When lat==0, transition to DRAIN.
- DRAIN:
  - ready_o=1.
  - A beat is accepted when valid_i && ready_o.
  - If cnt==0 on the accept: last_o=1 (combinational, same cycle) and go to DONE.
  - Otherwise cnt <= cnt-1.
  - No accept means no change.
- DONE: done_o=1 for this single cycle, then go to IDLE. ready_o=0.
- start_i outside IDLE is ignored. It does not reload or restart.
- cnt never wraps: it decrements only in DRAIN with cnt>0.
- valid_i outside DRAIN is ignored; no counter change.
- Reset (any state, including mid-drain):
  - state=IDLE, cnt=0, lat=0, err=0.
  - Outputs: ready_o=0, last_o=0, busy_o=0, done_o=0, cnt_o=0, err_o=0.
  - Takes effect on the next clk edge with rst_n=0.

## Timing
- Start sampled at the edge ending cycle t:
  - FILL occupies cycles t+1..t+LAT.
  - First ready_o in cycle t+LAT+1.
- With valid_i held high, beats are accepted in cycles t+LAT+1..t+LAT+N.
  - last_o is high in cycle t+LAT+N.
  - done_o is high in cycle t+LAT+N+1.
  - busy_o falls in cycle t+LAT+N+2, when a new start is accepted.
- Each valid_i gap extends DRAIN by one cycle; no other effect.
- ready_o, busy_o, done_o and cnt_o are registered-state decodes with no combinational path from inputs.
- last_o is combinational from valid_i.

## Configuration
- GEMM_DRAIN_ERR_EN defined:
  - err_o is a sticky register. It sets on valid_i while in FILL or DONE, or on start_i while busy_o=1.
  - It clears on reset or on the next accepted start_i in IDLE.
  - The offending event is otherwise still ignored.
- GEMM_DRAIN_ERR_EN undefined: err_o tied to 0 and no error logic is built.

## Test plan
Defaults: CNT=14, LAT=3.
- Reset, then start with len_i=4 and valid_i high continuously:
  - ready_o first high 4 cycles after start.
  - cnt_o goes 3,2,1,0.
  - last_o is high on the 4th beat.
  - done_o pulses one cycle later; busy_o drops the cycle after that.
- len_i=0, and separately len_i=15:
  - Each accepts exactly 14 beats; cnt_o starts at 13.
  - done_o follows the 14th beat.
- len_i=3 with valid_i toggling 1,0,1,0,1:
  - 3 accepts; last_o is on the 5th DRAIN cycle.
  - cnt_o holds during the gaps.
- start_i re-pulsed during FILL and DRAIN: ignored, beat total unchanged. With GEMM_DRAIN_ERR_EN, err_o=1 until the next start accepted in IDLE.
- rst_n=0 for one cycle after 2 of 6 beats:
  - All outputs are 0 the next cycle; ready_o stays 0.
  - A new start with len_i=2 then completes normally.
- LAT=0 build, start with len_i=1:
  - ready_o and last_o are high in cycle t+1 with valid_i=1.
  - done_o in cycle t+2.
